// File: rtl/turf_ram_arbiter.sv
// Single-port board RAM arbiter: clear engine, game port and display port share one access per
// cycle; game has priority but the display is guaranteed a slot after a bounded game burst.
module turf_ram_arbiter #(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DATA_W         = 3,
  parameter int unsigned DEPTH          = 32768,
  parameter int unsigned READ_LAT       = 1,
  parameter int unsigned GAME_BURST_MAX = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              g_req,
  input  logic              g_wr,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              g_gnt,
  output logic              g_rvalid,
  output logic [DATA_W-1:0] g_rdata,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_gnt,
  output logic              v_rvalid,
  output logic [DATA_W-1:0] v_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BURST_W = $clog2(GAME_BURST_MAX + 1);

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StServe = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [READ_LAT-1:0] gtag_q, vtag_q;
  logic [DATA_W-1:0]  grdata_q, vrdata_q;

  logic               g_gnt_c, v_gnt_c, wren_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [DATA_W-1:0]  wdata_c;
  logic               g_rd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    g_gnt_c = 1'b0;
    v_gnt_c = 1'b0;
    wren_c  = 1'b0;
    addr_c  = v_addr;
    wdata_c = g_wdata;
    unique case (state_q)
      StClear: begin
        wren_c  = 1'b1;
        addr_c  = ADDR_W'(cnt_q);
        wdata_c = '0;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = StServe;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end else begin
          // Display pre-empts the game once it has waited through a full burst.
          if (g_req && !(v_req && burst_q == BURST_W'(GAME_BURST_MAX))) begin
            g_gnt_c = 1'b1;
            addr_c  = g_addr;
            wren_c  = g_wr;
          end else if (v_req) begin
            v_gnt_c = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    burst_d = burst_q;
    if (!v_req || v_gnt_c) begin
      burst_d = '0;
    end else if (g_gnt_c && burst_q != BURST_W'(GAME_BURST_MAX)) begin
      burst_d = burst_q + BURST_W'(1);
    end
  end

  // Reset forces every output to its quiescent value within the reset cycle itself.
  always_comb begin
    g_gnt       = g_gnt_c & ~reset;
    v_gnt       = v_gnt_c & ~reset;
    ram_wren    = wren_c & ~reset;
    ram_address = reset ? '0 : addr_c;
    ram_data    = reset ? '0 : wdata_c;
    clear_busy  = reset | (state_q == StClear);
    clear_done  = done_q & ~reset;
    g_rvalid    = gtag_q[READ_LAT-1] & ~reset;
    v_rvalid    = vtag_q[READ_LAT-1] & ~reset;
    g_rdata     = reset ? '0 : (g_rvalid ? ram_q : grdata_q);
    v_rdata     = reset ? '0 : (v_rvalid ? ram_q : vrdata_q);
  end

  assign g_rd = g_gnt & ~g_wr;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StClear;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      burst_q  <= '0;
      gtag_q   <= '0;
      vtag_q   <= '0;
      grdata_q <= '0;
      vrdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      burst_q   <= burst_d;
      gtag_q[0] <= g_rd;
      vtag_q[0] <= v_gnt;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        gtag_q[i] <= gtag_q[i-1];
        vtag_q[i] <= vtag_q[i-1];
      end
      grdata_q  <= g_rdata;
      vrdata_q  <= v_rdata;
    end
  end

endmodule

// File: tb/tb_turf_ram_arbiter.sv
// Scoreboard bench for turf_ram_arbiter: a behavioural model predicts grants, RAM traffic and
// read returns; a separate monitor pops expected reads whenever the DUT raises an rvalid.
module tb_turf_ram_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 32768;
  localparam int BMAX   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, clear_req, clear_busy, clear_done;
  logic              g_req, g_wr, g_gnt, g_rvalid;
  logic [ADDR_W-1:0] g_addr, v_addr, ram_address;
  logic [DATA_W-1:0] g_wdata, g_rdata, v_rdata, ram_data, ram_q;
  logic              v_req, v_gnt, v_rvalid, ram_wren;

  turf_ram_arbiter dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .g_req      (g_req),
    .g_wr       (g_wr),
    .g_addr     (g_addr),
    .g_wdata    (g_wdata),
    .g_gnt      (g_gnt),
    .g_rvalid   (g_rvalid),
    .g_rdata    (g_rdata),
    .v_req      (v_req),
    .v_addr     (v_addr),
    .v_gnt      (v_gnt),
    .v_rvalid   (v_rvalid),
    .v_rdata    (v_rdata),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  // Write-first single-port RAM, one cycle read latency.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_q <= ram_wren ? ram_data : ram_mem[ram_address];
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  longint      cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [DATA_W-1:0] d;
    longint            due;
  } rd_t;
  rd_t gq[$];
  rd_t vq[$];

  logic [DATA_W-1:0] smem [DEPTH];
  bit m_serve = 0;
  int m_cnt   = 0;
  int m_wait  = 0;   // game grants given since the display started waiting
  bit m_done  = 0;

  always @(negedge clk) begin
    bit eg, ev, ew, eb, ed;
    int ea, edat;
    if (cyc > 0) begin
      eg = 0; ev = 0; ew = 0; eb = 0; ed = 0; ea = 0; edat = 0;
      if (reset) begin
        eb = 1;
        m_serve = 0; m_cnt = 0; m_wait = 0; m_done = 0;
        gq.delete();
        vq.delete();
      end else if (!m_serve) begin
        eb = 1; ew = 1; ea = m_cnt; edat = 0;
        smem[m_cnt] = '0;
        if (m_cnt == DEPTH - 1) begin
          m_serve = 1;
          m_done  = 1;
        end else begin
          m_cnt++;
        end
        if (!v_req) m_wait = 0;
      end else begin
        ed = m_done; m_done = 0;
        ea = int'(v_addr); edat = int'(g_wdata);
        if (clear_req) begin
          m_serve = 0;
          m_cnt   = 0;
        end else begin
          eg = g_req && !(v_req && m_wait >= BMAX);
          ev = v_req && !eg;
          if (eg) begin
            ea = int'(g_addr);
            ew = g_wr;
            if (g_wr) smem[g_addr] = g_wdata;
            else gq.push_back('{d: smem[g_addr], due: cyc + 1});
          end
          if (ev) vq.push_back('{d: smem[v_addr], due: cyc + 1});
        end
        if (!v_req || ev) m_wait = 0;
        else if (eg && m_wait < BMAX) m_wait++;
      end
      chk("g_gnt", g_gnt, eg);
      chk("v_gnt", v_gnt, ev);
      chk("ram_wren", ram_wren, ew);
      chk("ram_address", ram_address, ea);
      chk("ram_data", ram_data, edat);
      chk("clear_busy", clear_busy, eb);
      chk("clear_done", clear_done, ed);
    end
  end

  // ---------------- read-return monitor ----------------
  logic [DATA_W-1:0] g_last = '0;
  logic [DATA_W-1:0] v_last = '0;

  always @(negedge clk) begin
    rd_t e;
    if (cyc > 0) begin
      if (reset) begin
        chk("g_rvalid_in_reset", g_rvalid, 0);
        chk("v_rvalid_in_reset", v_rvalid, 0);
        chk("g_rdata_in_reset", g_rdata, 0);
        chk("v_rdata_in_reset", v_rdata, 0);
        g_last = '0;
        v_last = '0;
      end else begin
        if (g_rvalid) begin
          if (gq.size() == 0) chk("g_rvalid_unexpected", g_rvalid, 0);
          else begin
            e = gq.pop_front();
            chk("g_rdata", g_rdata, e.d);
            chk("g_rvalid_latency", cyc, e.due);
            g_last = e.d;
          end
        end else begin
          if (gq.size() > 0 && gq[0].due <= cyc) begin
            chk("g_rvalid_missing", g_rvalid, 1);
            void'(gq.pop_front());
          end
          chk("g_rdata_hold", g_rdata, g_last);
        end
        if (v_rvalid) begin
          if (vq.size() == 0) chk("v_rvalid_unexpected", v_rvalid, 0);
          else begin
            e = vq.pop_front();
            chk("v_rdata", v_rdata, e.d);
            chk("v_rvalid_latency", cyc, e.due);
            v_last = e.d;
          end
        end else begin
          if (vq.size() > 0 && vq[0].due <= cyc) begin
            chk("v_rvalid_missing", v_rvalid, 1);
            void'(vq.pop_front());
          end
          chk("v_rdata_hold", v_rdata, v_last);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic game_op(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         output int n);
    bit got = 0;
    n = 0;
    g_req = 1; g_wr = wr; g_addr = a; g_wdata = d;
    while (!got && n < DEPTH + 100) begin
      @(negedge clk);
      got = g_gnt;
      @(posedge clk);
      #1;
      if (!got) n++;
    end
    g_req = 0;
    if (!got) chk("game_grant_timeout", got, 1);
  endtask

  task automatic disp_op(input logic [ADDR_W-1:0] a, output int n);
    bit got = 0;
    n = 0;
    v_req = 1; v_addr = a;
    while (!got && n < 200) begin
      @(negedge clk);
      got = v_gnt;
      @(posedge clk);
      #1;
      if (!got) n++;
    end
    v_req = 0;
    if (!got) chk("disp_grant_timeout", got, 1);
  endtask

  task automatic wait_clear_done(output int n);
    n = 0;
    while (n < DEPTH + 100) begin
      @(negedge clk);
      if (clear_done) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, gc, vc, rv;
    bit gg, vg;
    reset = 1; clear_req = 0; g_req = 0; g_wr = 0; g_addr = '0; g_wdata = '0;
    v_req = 0; v_addr = '0;
    @(posedge clk); #1 reset = 0;

    // Reset part-way through the power-up clear, then let the full clear run.
    repeat (1000) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    wait_clear_done(n);
    chk("clear_length", n, DEPTH);

    // Write then read back-to-back at the same address.
    game_op(1, 15'h4F77, 3'b001, n);
    chk("wr_grant_wait", n, 0);
    game_op(0, 15'h4F77, 3'b000, n);
    chk("rd_grant_wait", n, 0);

    // Both requesting continuously: 8 game grants per display grant.
    g_req = 1; g_wr = 0; g_addr = 15'h0123; v_req = 1; v_addr = 15'h0456;
    gc = 0; vc = 0;
    repeat (20) begin
      @(negedge clk);
      gc += int'(g_gnt);
      vc += int'(v_gnt);
      @(posedge clk); #1;
    end
    g_req = 0; v_req = 0;
    chk("contention_g_grants", gc, 18);
    chk("contention_v_grants", vc, 2);

    // Display reads back-to-back from preloaded locations.
    game_op(1, 15'h0001, 3'b010, n);
    game_op(1, 15'h0002, 3'b100, n);
    disp_op(15'h0001, n);
    chk("disp_rd1_wait", n, 0);
    disp_op(15'h0002, n);
    chk("disp_rd2_wait", n, 0);
    repeat (3) @(posedge clk);
    #1;

    // Randomised traffic on a small address window, honouring hold-until-granted.
    gg = 1; vg = 1;
    for (int i = 0; i < 400; i++) begin
      if (!g_req || gg) begin
        g_req   = ($urandom_range(0, 9) < 8);
        g_wr    = 1'($urandom_range(0, 1));
        g_addr  = ADDR_W'(32'h100 + $urandom_range(0, 15));
        g_wdata = DATA_W'($urandom_range(0, 7));
      end
      if (!v_req || vg) begin
        v_req  = ($urandom_range(0, 9) < 7);
        v_addr = ADDR_W'(32'h100 + $urandom_range(0, 15));
      end
      @(negedge clk);
      gg = g_gnt;
      vg = v_gnt;
      @(posedge clk); #1;
    end
    g_req = 0; v_req = 0;
    repeat (3) @(posedge clk);
    #1;

    // clear_req beats a simultaneous game request; game waits for the whole clear.
    g_req = 1; g_wr = 0; g_addr = 15'h4F77; clear_req = 1;
    @(negedge clk);
    chk("clear_req_blocks_game", g_gnt, 0);
    @(posedge clk); #1 clear_req = 0;
    game_op(0, 15'h4F77, 3'b000, n);
    chk("clear_req_grant_delay", n, DEPTH);
    repeat (2) @(posedge clk);
    #1;

    // Reset the cycle after a display read grant: that read must never return.
    disp_op(15'h0002, n);
    reset = 1;
    rv = 0;
    @(negedge clk);
    rv += int'(v_rvalid);
    @(posedge clk); #1 reset = 0;
    repeat (5) begin
      @(negedge clk);
      rv += int'(v_rvalid);
      @(posedge clk); #1;
    end
    chk("no_rvalid_after_reset", rv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
